// File: rtl/exec_ctrl.sv
// Three-state instruction sequencer: reads operands from a 4x6 register file,
// drives an external ALU for one cycle, writes back and holds the result until taken.
module exec_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic [5:0] imm,
  output logic [5:0] alu_a,
  output logic [5:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [5:0] alu_r,
  input  logic       alu_cf,
  input  logic       alu_zf,
  input  logic       alu_sf,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_data,
  output logic [2:0] res_flags
);

  localparam logic [1:0] OP_LDI = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0][5:0] rf_q, rf_d;
  logic [1:0]      rd_q, rd_d;
  logic            ldi_q, ldi_d;
  logic [5:0]      imm_q, imm_d;
  logic [5:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic [5:0]      res_data_q, res_data_d;
  logic [2:0]      res_flags_q, res_flags_d;
  logic            live_q;
  logic            accept;

  // live_q keeps instr_ready low while in reset and rises on the first edge after it
  assign instr_ready = live_q & (state_q == IDLE);
  assign res_valid   = (state_q == RESP);
  assign accept      = instr_valid & instr_ready;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign res_data    = res_data_q;
  assign res_flags   = res_flags_q;

  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    rd_d        = rd_q;
    ldi_d       = ldi_q;
    imm_d       = imm_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    case (state_q)
      IDLE: if (accept) begin
        rd_d     = instr[5:4];
        ldi_d    = (instr[7:6] == OP_LDI);
        imm_d    = imm;
        alu_a_d  = rf_q[instr[3:2]];
        alu_b_d  = rf_q[instr[1:0]];
        alu_op_d = (instr[7:6] == OP_LDI) ? 2'b00 : instr[7:6];
        state_d  = EXEC;
      end
      EXEC: begin
        // Write-back happens only here, so rd aliasing rs/rt is harmless
        if (ldi_q) begin
          rf_d[rd_q]  = imm_q;
          res_data_d  = imm_q;
          res_flags_d = {imm_q[5], imm_q == 6'd0, 1'b0};
        end else begin
          rf_d[rd_q]  = alu_r;
          res_data_d  = alu_r;
          res_flags_d = {alu_sf, alu_zf, alu_cf};
        end
        state_d = RESP;
      end
      RESP: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rf_q        <= '0;
      rd_q        <= 2'b00;
      ldi_q       <= 1'b0;
      imm_q       <= 6'd0;
      alu_a_q     <= 6'd0;
      alu_b_q     <= 6'd0;
      alu_op_q    <= 2'b00;
      res_data_q  <= 6'd0;
      res_flags_q <= 3'b000;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      rd_q        <= rd_d;
      ldi_q       <= ldi_d;
      imm_q       <= imm_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      live_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with a behavioural 6-bit ALU attached.
module tb_exec_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0, instr_ready;
  logic [7:0] instr = 8'h00;
  logic [5:0] imm = 6'd0;
  logic [5:0] alu_a, alu_b, alu_r;
  logic [1:0] alu_op;
  logic       alu_cf, alu_zf, alu_sf;
  logic       res_valid, res_ready = 1'b1;
  logic [5:0] res_data;
  logic [2:0] res_flags;
  int errs = 0, chks = 0;

  localparam logic [1:0] XOR = 2'b00, ADD = 2'b01, SHR = 2'b10, LDI = 2'b11;

  exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_sf(alu_sf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags)
  );

  always #5 clk = ~clk;

  logic [6:0] alu_full;
  always_comb begin
    case (alu_op)
      2'b00:   alu_full = {1'b0, alu_a ^ alu_b};
      2'b01:   alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      2'b10:   alu_full = {1'b0, alu_a >> alu_b};
      default: alu_full = 7'd0;
    endcase
  end
  assign alu_r  = alu_full[5:0];
  assign alu_cf = alu_full[6];
  assign alu_zf = (alu_full[5:0] == 6'd0);
  assign alu_sf = alu_full[5];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Drives one instruction; returns EXEC-cycle operands, result and edges to res_valid
  task automatic run(input logic [1:0] op, rd, rs, rt, input logic [5:0] im, input logic rr,
                     output logic [5:0] a, b, output logic [1:0] o,
                     output logic [5:0] d, output logic [2:0] f, output int lat);
    int n;
    res_ready = 1'b1;
    n = 0;
    while (!instr_ready && n < 10) begin tick; n++; end
    res_ready   = rr;
    instr_valid = 1'b1;
    instr       = {op, rd, rs, rt};
    imm         = im;
    tick;
    instr_valid = 1'b0;
    instr       = 8'($urandom);
    imm         = 6'($urandom);
    a = alu_a; b = alu_b; o = alu_op;
    lat = 1;
    if (res_valid) lat = -1;
    else begin
      do begin tick; lat++; end while (!res_valid && lat < 10);
      if (!res_valid) lat = -1;
    end
    d = res_data; f = res_flags;
    if (rr) tick;
  endtask

  logic [5:0] a, b, d;
  logic [1:0] o;
  logic [2:0] f;
  int lat;

  task automatic test_reset;
    #2;
    chks++; if (instr_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %b want 0", instr_ready); end
    chks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", res_valid); end
    chks++; if ({alu_a, alu_b, alu_op, res_data, res_flags} !== 23'd0)
      begin errs++; $display("FAIL rst_outs got %h want 0", {alu_a, alu_b, alu_op, res_data, res_flags}); end
    tick; tick;
    rst_n = 1'b1; #1;
    chks++; if (instr_ready !== 1'b0) begin errs++; $display("FAIL rel_ready_early got %b want 0", instr_ready); end
    tick;
    chks++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL rel_ready got %b want 1", instr_ready); end
  endtask

  task automatic test_add;
    run(LDI, 2'd1, 2'd0, 2'd0, 6'd5, 1'b1, a, b, o, d, f, lat);
    chks++; if (o !== 2'b00) begin errs++; $display("FAIL ldi_aluop got %b want 00", o); end
    chks++; if (d !== 6'd5) begin errs++; $display("FAIL ldi5 got %0d want 5", d); end
    run(LDI, 2'd2, 2'd0, 2'd0, 6'd3, 1'b1, a, b, o, d, f, lat);
    run(ADD, 2'd3, 2'd1, 2'd2, 6'd0, 1'b1, a, b, o, d, f, lat);
    chks++; if ({a, b, o} !== {6'd5, 6'd3, ADD}) begin errs++; $display("FAIL add_ops got %0d,%0d,%0d want 5,3,1", a, b, o); end
    chks++; if (d !== 6'd8 || f !== 3'b000) begin errs++; $display("FAIL add_res got %0d/%b want 8/000", d, f); end
    chks++; if (lat !== 2) begin errs++; $display("FAIL add_latency got %0d want 2", lat); end
    run(XOR, 2'd0, 2'd3, 2'd3, 6'd0, 1'b1, a, b, o, d, f, lat);
    chks++; if (a !== 6'd8) begin errs++; $display("FAIL r3_wb got %0d want 8", a); end
  endtask

  task automatic test_shr;
    run(LDI, 2'd1, 2'd0, 2'd0, 6'd40, 1'b1, a, b, o, d, f, lat);
    chks++; if (f !== 3'b100) begin errs++; $display("FAIL ldi40_flags got %b want 100", f); end
    run(LDI, 2'd2, 2'd0, 2'd0, 6'd2, 1'b1, a, b, o, d, f, lat);
    run(SHR, 2'd3, 2'd1, 2'd2, 6'd0, 1'b1, a, b, o, d, f, lat);
    chks++; if (o !== SHR || d !== 6'd10 || f !== 3'b000) begin errs++; $display("FAIL shr got op%0d %0d/%b want op2 10/000", o, d, f); end
  endtask

  task automatic test_carry;
    run(LDI, 2'd1, 2'd0, 2'd0, 6'd63, 1'b1, a, b, o, d, f, lat);
    run(LDI, 2'd2, 2'd0, 2'd0, 6'd1, 1'b1, a, b, o, d, f, lat);
    run(ADD, 2'd0, 2'd1, 2'd2, 6'd0, 1'b1, a, b, o, d, f, lat);
    chks++; if (d !== 6'd0 || f !== 3'b011) begin errs++; $display("FAIL add_wrap got %0d/%b want 0/011", d, f); end
    run(LDI, 2'd2, 2'd0, 2'd0, 6'd32, 1'b1, a, b, o, d, f, lat);
    chks++; if (d !== 6'd32 || f !== 3'b100) begin errs++; $display("FAIL ldi32 got %0d/%b want 32/100", d, f); end
    run(LDI, 2'd0, 2'd0, 2'd0, 6'd0, 1'b1, a, b, o, d, f, lat);
    chks++; if (f !== 3'b010) begin errs++; $display("FAIL ldi0_flags got %b want 010", f); end
  endtask

  task automatic test_xor_self;
    run(LDI, 2'd1, 2'd0, 2'd0, 6'd42, 1'b1, a, b, o, d, f, lat);
    run(XOR, 2'd1, 2'd1, 2'd1, 6'd0, 1'b1, a, b, o, d, f, lat);
    chks++; if (a !== 6'd42 || b !== 6'd42) begin errs++; $display("FAIL xor_ops got %0d,%0d want 42,42", a, b); end
    chks++; if (d !== 6'd0 || f !== 3'b010) begin errs++; $display("FAIL xor_self got %0d/%b want 0/010", d, f); end
    run(ADD, 2'd0, 2'd1, 2'd1, 6'd0, 1'b1, a, b, o, d, f, lat);
    chks++; if (a !== 6'd0) begin errs++; $display("FAIL r1_zero got %0d want 0", a); end
  endtask

  task automatic test_hold;
    run(LDI, 2'd2, 2'd0, 2'd0, 6'd9, 1'b0, a, b, o, d, f, lat);
    chks++; if (d !== 6'd9 || lat !== 2) begin errs++; $display("FAIL hold_entry got %0d lat %0d want 9 lat 2", d, lat); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin instr_valid = 1'b1; instr = {LDI, 2'd3, 4'd0}; imm = 6'd17; end
      tick;
      instr_valid = 1'b0;
      chks++;
      if (res_valid !== 1'b1 || instr_ready !== 1'b0 || res_data !== 6'd9 || res_flags !== 3'b000) begin
        errs++; $display("FAIL hold_%0d got v%b r%b %0d/%b want v1 r0 9/000", i, res_valid, instr_ready, res_data, res_flags);
      end
    end
    res_ready = 1'b1;
    tick;
    chks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin errs++; $display("FAIL hold_release got v%b r%b want v0 r1", res_valid, instr_ready); end
    run(XOR, 2'd0, 2'd3, 2'd2, 6'd0, 1'b1, a, b, o, d, f, lat);
    chks++; if (a !== 6'd10 || b !== 6'd9) begin errs++; $display("FAIL ignored_instr got r3=%0d r2=%0d want 10,9", a, b); end
  endtask

  task automatic test_reset_exec;
    run(LDI, 2'd1, 2'd0, 2'd0, 6'd5, 1'b1, a, b, o, d, f, lat);
    run(LDI, 2'd2, 2'd0, 2'd0, 6'd3, 1'b1, a, b, o, d, f, lat);
    instr_valid = 1'b1; instr = {ADD, 2'd3, 2'd1, 2'd2};
    tick;
    instr_valid = 1'b0;
    chks++; if (alu_a !== 6'd5 || alu_b !== 6'd3) begin errs++; $display("FAIL pre_rst_exec got %0d,%0d want 5,3", alu_a, alu_b); end
    rst_n = 1'b0; #1;
    chks++; if ({alu_a, alu_b, alu_op, res_data, res_flags, res_valid, instr_ready} !== 25'd0)
      begin errs++; $display("FAIL rst_exec got %h want 0", {alu_a, alu_b, alu_op, res_data, res_flags, res_valid, instr_ready}); end
    tick; tick;
    rst_n = 1'b1; #1;
    chks++; if (instr_ready !== 1'b0 || res_valid !== 1'b0) begin errs++; $display("FAIL rst_exec_rel got r%b v%b want r0 v0", instr_ready, res_valid); end
    tick;
    chks++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL rst_exec_ready got %b want 1", instr_ready); end
    run(ADD, 2'd0, 2'd3, 2'd1, 6'd0, 1'b1, a, b, o, d, f, lat);
    chks++; if (a !== 6'd0 || b !== 6'd0 || d !== 6'd0) begin errs++; $display("FAIL rst_regs got r3=%0d r1=%0d d=%0d want 0", a, b, d); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] ims [5];
    logic [5:0] expd;
    int k, last, nresp;
    ims[0] = 6'd7; ims[1] = 6'd0; ims[2] = 6'd33; ims[3] = 6'd21; ims[4] = 6'd63;
    k = 0; last = -1; nresp = 0; expd = 6'd0;
    res_ready = 1'b1;
    instr_valid = 1'b1; instr = {LDI, 2'd0, 4'd0}; imm = ims[0];
    for (int cyc = 0; cyc < 30; cyc++) begin
      logic acc;
      acc = instr_valid & instr_ready;
      if (res_valid) begin
        nresp++;
        chks++; if (res_data !== expd) begin errs++; $display("FAIL b2b_data%0d got %0d want %0d", nresp, res_data, expd); end
      end
      if (acc) begin
        if (k > 0) begin
          chks++; if (cyc - last !== 3) begin errs++; $display("FAIL b2b_spacing got %0d want 3", cyc - last); end
        end
        last = cyc;
      end
      tick;
      if (acc) begin
        expd = ims[k];
        k++;
        if (k < 5) begin instr = {LDI, 2'(k), 4'd0}; imm = ims[k]; end
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    chks++; if (k !== 5 || nresp !== 5) begin errs++; $display("FAIL b2b_count got acc %0d resp %0d want 5/5", k, nresp); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_shr;
    test_carry;
    test_xor_self;
    test_hold;
    test_reset_exec;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be asynchronous and active-low.
REQ-002 Port list (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr  in  8  [7:6] op, [5:4] rd, [3:2] rs, [1:0] rt
- imm  in  6  immediate for LDI, sampled with instr
- alu_a  out  6  ALU operand A, registered
- alu_b  out  6  ALU operand B, registered
- alu_op  out  2  ALU opcode: 00 XOR, 01 ADD, 10 SHR
- alu_r  in  6  ALU result, combinational from alu_a/alu_b/alu_op
- alu_cf, alu_zf, alu_sf  in  1 each  ALU flags
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  6  written-back value
- res_flags  out  3  {SF,ZF,CF} of the result
REQ-003 op encoding: 00 XOR, 01 ADD, 10 SHR, 11 LDI (rd <= imm; ALU not used).

Function
REQ-004 The block SHALL hold a 4 x 6-bit register file r0..r3; all four registers SHALL be writable.
REQ-005 FSM states SHALL be IDLE, EXEC and RESP.
REQ-006 IDLE: instr_ready=1 and res_valid=0.
- On instr_valid & instr_ready at a clock edge: latch rd and op.
- Load alu_a<=r[rs], alu_b<=r[rt], alu_op<=op; for LDI load alu_op<=00.
- Go to EXEC.
REQ-007 EXEC (exactly one cycle): instr_ready=0; alu_a/alu_b/alu_op SHALL be stable for the whole cycle.
REQ-008 At the edge ending EXEC, for ALU ops:
- r[rd]<=alu_r and res_data<=alu_r.
- res_flags<={alu_sf,alu_zf,alu_cf}.
- Go to RESP.
REQ-009 At the same edge for LDI:
- r[rd]<=imm and res_data<=imm.
- res_flags<={imm[5], imm==0, 0}.
- Go to RESP.
REQ-010 RESP: res_valid=1, instr_ready=0; res_data and res_flags SHALL be stable until handshake. On res_valid & res_ready, go to IDLE.
REQ-011 Latency: an instruction accepted at edge t SHALL present res_valid=1 from edge t+2. With res_ready held high, one instruction completes every 3 cycles.
REQ-012 instr_valid while instr_ready=0 SHALL be ignored; instr and imm SHALL be sampled only at the accepting edge.
REQ-013 res_ready while res_valid=0 SHALL be ignored.
REQ-014 alu_a, alu_b and alu_op SHALL retain their last values outside EXEC.
REQ-015 rs==rt, rd==rs and rd==rt SHALL be legal: operands are read at acceptance, and write-back occurs only at the end of EXEC.
REQ-016 All arithmetic SHALL be 6-bit; no carry SHALL be stored beyond res_flags.

Reset
REQ-017 While rst_n=0 the following SHALL hold:
- State IDLE; r0..r3=0.
- alu_a=0, alu_b=0, alu_op=00.
- res_data=0, res_flags=000, res_valid=0, instr_ready=0.
REQ-018 From the first edge after rst_n rises, instr_ready SHALL be 1.
REQ-019 Reset asserted in EXEC or RESP SHALL discard the in-flight instruction: no register write, no res_valid.

Verification
REQ-020 LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> res_data=8, res_flags=000, r3=8, res_valid exactly 2 edges after ADD acceptance.
REQ-021 LDI r1,63; LDI r2,1; ADD r0,r1,r2 -> res_data=0, res_flags=011 (ZF=1, CF=1); LDI r2,32 -> res_flags=100.
REQ-022 LDI r1,42; XOR r1,r1,r1 -> res_data=0, ZF=1, r1=0.
REQ-023 Hold res_ready=0 for 5 cycles in RESP -> res_valid=1 and res_data/res_flags constant; instr_ready=0; a pulsed instr_valid is ignored; release -> IDLE next edge.
REQ-024 Assert rst_n=0 during EXEC of ADD r3 -> all outputs and registers 0 immediately; r3 remains 0 after release; instr_ready=1 one edge after release.
REQ-025 Back-to-back LDIs with instr_valid and res_ready held high -> one accept every 3 cycles; each res_data matches its imm.
